// File: rtl/sensor_cond_pkg.sv
// Shared types and constants for the sensor conditioner.
package sensor_cond_pkg;

  typedef enum logic [1:0] {SC_LOW, SC_ARM_H, SC_HIGH, SC_ARM_L} sc_state_t;

  localparam logic [7:0] GLITCH_MAX = 8'hFF;

endpackage

// File: rtl/sensor_debounce_ch.sv
// One sensor channel: synchroniser, debounce FSM and qualification counter.
// States: LOW stable low, ARM_H qualifying high, HIGH stable high, ARM_L qualifying low.
module sensor_debounce_ch
  import sensor_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic settled,
  output logic glitch
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  sc_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_next;
  logic [CNT_W-1:0]       stab_q, stab_d, stab_inc;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   glitch_q, glitch_d;
  logic                   settled_q, settled_d;
  logic                   s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw};
  assign s      = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stab_d    = stab_q;
    level_d   = level_q;
    rise_d    = 1'b0;
    glitch_d  = 1'b0;
    settled_d = settled_q;
    cnt_next  = (state_q == SC_LOW || state_q == SC_HIGH) ? CNT_ONE :
                (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    stab_inc  = (stab_q == CNT_MAX) ? stab_q : stab_q + 1'b1;

    if (!en) begin
      // Park in the state that matches the held output so re-enable starts clean.
      state_d = level_q ? SC_HIGH : SC_LOW;
      cnt_d   = '0;
      stab_d  = '0;
    end else begin
      unique case (state_q)
        SC_LOW, SC_ARM_H: begin
          if (s) begin
            if (cnt_next == CNT_MAX) begin
              state_d = SC_HIGH;
              level_d = 1'b1;
              rise_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = SC_ARM_H;
              cnt_d   = cnt_next;
            end
          end else if (state_q == SC_ARM_H) begin
            state_d  = SC_LOW;
            cnt_d    = '0;
            glitch_d = 1'b1;
          end
        end
        SC_HIGH, SC_ARM_L: begin
          if (!s) begin
            if (cnt_next == CNT_MAX) begin
              state_d = SC_LOW;
              level_d = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = SC_ARM_L;
              cnt_d   = cnt_next;
            end
          end else if (state_q == SC_ARM_L) begin
            state_d  = SC_HIGH;
            cnt_d    = '0;
            glitch_d = 1'b1;
          end
        end
      endcase

      // Initial qualification: consecutive enabled cycles spent in a stable state.
      if (state_q == SC_LOW || state_q == SC_HIGH) begin
        stab_d = stab_inc;
        if (stab_inc == CNT_MAX) settled_d = 1'b1;
      end else begin
        stab_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= SC_LOW;
      cnt_q     <= '0;
      stab_q    <= '0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      glitch_q  <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stab_q    <= stab_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      glitch_q  <= glitch_d;
      settled_q <= settled_d;
    end
  end

  assign level   = level_q;
  assign rise    = rise_q;
  assign settled = settled_q;
  assign glitch  = glitch_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Left/right sensor front end: two debounce channels plus valid, en_o and glitch count.
// Optional glitch counter enabled by defining SENSOR_GLITCH_CNT_EN.
module sensor_conditioner
  import sensor_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       ls_raw,
  input  logic       rs_raw,
  output logic       ls,
  output logic       rs,
  output logic       ls_rise,
  output logic       rs_rise,
  output logic       valid,
  output logic       en_o
`ifdef SENSOR_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  logic settled_l, settled_r;
  logic glitch_l, glitch_r;
  logic valid_q, valid_d;
  logic en_q, en_d;

  sensor_debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch_l (
    .clk    (clk),
    .rst    (rst),
    .en     (en_i),
    .raw    (ls_raw),
    .level  (ls),
    .rise   (ls_rise),
    .settled(settled_l),
    .glitch (glitch_l)
  );

  sensor_debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch_r (
    .clk    (clk),
    .rst    (rst),
    .en     (en_i),
    .raw    (rs_raw),
    .level  (rs),
    .rise   (rs_rise),
    .settled(settled_r),
    .glitch (glitch_r)
  );

  always_comb begin
    valid_d = valid_q | (settled_l & settled_r);
    en_d    = en_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      en_q    <= en_d;
    end
  end

  assign valid = valid_q;
  assign en_o  = en_q;

`ifdef SENSOR_GLITCH_CNT_EN
  logic [7:0] glitch_cnt_q, glitch_cnt_d;
  logic [8:0] glitch_sum;

  always_comb begin
    glitch_sum   = {1'b0, glitch_cnt_q} + 9'(glitch_l) + 9'(glitch_r);
    glitch_cnt_d = (glitch_sum > 9'(GLITCH_MAX)) ? GLITCH_MAX : glitch_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) glitch_cnt_q <= '0;
    else     glitch_cnt_q <= glitch_cnt_d;
  end

  assign glitch_cnt = glitch_cnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = glitch_l ^ glitch_r;
`endif

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner (default parameters: 2 sync stages, 4 debounce cycles).
module tb_sensor_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_i;
  logic       ls_raw;
  logic       rs_raw;
  logic       ls, rs, ls_rise, rs_rise, valid, en_o;
`ifdef SENSOR_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  integer tests_run    = 0;
  integer tests_failed = 0;

  always #5 clk = ~clk;

  sensor_conditioner dut (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en_i),
    .ls_raw (ls_raw),
    .rs_raw (rs_raw),
    .ls     (ls),
    .rs     (rs),
    .ls_rise(ls_rise),
    .rs_rise(rs_rise),
    .valid  (valid),
    .en_o   (en_o)
`ifdef SENSOR_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en_i = 1'b1; ls_raw = 1'b0; rs_raw = 1'b0;
    repeat (3) step();
    tests_run++;
    if ({ls, rs, ls_rise, rs_rise, valid, en_o} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%b want=000000", {ls, rs, ls_rise, rs_rise, valid, en_o});
    end
`ifdef SENSOR_GLITCH_CNT_EN
    tests_run++;
    if (glitch_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_glitch_cnt got=%0d want=0", glitch_cnt);
    end
`endif
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 1) begin
        tests_run++;
        if (en_o !== 1'b1) begin
          tests_failed++;
          $display("FAIL en_o_follow got=%b want=1", en_o);
        end
      end
      if (i >= 4) begin
        tests_run++;
        if (valid !== (i == 5)) begin
          tests_failed++;
          $display("FAIL valid_timing step=%0d got=%b want=%b", i, valid, (i == 5));
        end
      end
    end
  endtask

  task automatic test_rise_latency();
    ls_raw = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      tests_run++;
      if (ls !== (i >= 6) || ls_rise !== (i == 6)) begin
        tests_failed++;
        $display("FAIL ls_latency step=%0d got ls=%b rise=%b want ls=%b rise=%b",
                 i, ls, ls_rise, (i >= 6), (i == 6));
      end
    end
  endtask

  task automatic test_glitch_reject();
    rs_raw = 1'b1;
    repeat (3) step();
    rs_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      tests_run++;
      if (rs !== 1'b0 || rs_rise !== 1'b0) begin
        tests_failed++;
        $display("FAIL rs_glitch step=%0d got rs=%b rise=%b want 0/0", i, rs, rs_rise);
      end
    end
`ifdef SENSOR_GLITCH_CNT_EN
    tests_run++;
    if (glitch_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL glitch_cnt_one got=%0d want=1", glitch_cnt);
    end
`endif
  endtask

  task automatic test_simultaneous();
    ls_raw = 1'b0;
    repeat (8) step();
    tests_run++;
    if (ls !== 1'b0) begin
      tests_failed++;
      $display("FAIL ls_fall got=%b want=0", ls);
    end
    ls_raw = 1'b1; rs_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      tests_run++;
      if (ls_rise !== (i == 6) || rs_rise !== (i == 6)) begin
        tests_failed++;
        $display("FAIL same_cycle_rise step=%0d got ls_rise=%b rs_rise=%b want %b",
                 i, ls_rise, rs_rise, (i == 6));
      end
    end
  endtask

  task automatic test_enable_hold();
    en_i = 1'b0; ls_raw = 1'b0; rs_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      tests_run++;
      if (ls !== 1'b1 || rs !== 1'b1 || en_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL disable_hold step=%0d got ls=%b rs=%b en_o=%b want 1/1/0", i, ls, rs, en_o);
      end
    end
    en_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      tests_run++;
      if (ls !== (i < 4) || rs !== (i < 4)) begin
        tests_failed++;
        $display("FAIL reenable_fall step=%0d got ls=%b rs=%b want %b", i, ls, rs, (i < 4));
      end
    end
  endtask

  task automatic test_reset_mid();
    rs_raw = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if (rs !== 1'b0 || valid !== 1'b0 || en_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset got rs=%b valid=%b en_o=%b want 0/0/0", rs, valid, en_o);
    end
`ifdef SENSOR_GLITCH_CNT_EN
    tests_run++;
    if (glitch_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_glitch_cnt got=%0d want=0", glitch_cnt);
    end
`endif
    for (int i = 1; i <= 6; i++) begin
      step();
      tests_run++;
      if (rs !== (i == 6) || rs_rise !== (i == 6)) begin
        tests_failed++;
        $display("FAIL post_reset_latency step=%0d got rs=%b rise=%b want %b",
                 i, rs, rs_rise, (i == 6));
      end
    end
  endtask

  task automatic test_glitch_sat();
    for (int i = 0; i < 100; i++) begin
      ls_raw = 1'b1; step();
      ls_raw = 1'b0; step(); step();
    end
    repeat (5) step();
    tests_run++;
    if (ls !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_train_ls got=%b want=0", ls);
    end
`ifdef SENSOR_GLITCH_CNT_EN
    tests_run++;
    if (glitch_cnt !== 8'd100) begin
      tests_failed++;
      $display("FAIL glitch_cnt_100 got=%0d want=100", glitch_cnt);
    end
    for (int i = 0; i < 200; i++) begin
      ls_raw = 1'b1; step();
      ls_raw = 1'b0; step(); step();
    end
    repeat (5) step();
    tests_run++;
    if (glitch_cnt !== 8'd255) begin
      tests_failed++;
      $display("FAIL glitch_cnt_sat got=%0d want=255", glitch_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_glitch_reject();
    test_simultaneous();
    test_enable_hold();
    test_reset_mid();
    test_glitch_sat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
